// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, IF/ID register, HALT detection and fetch counter.
// The instruction ROM is combinational, so the word for imem_pc is captured on the next edge.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    input  logic [15:0] imem_instr,
    output logic [15:0] imem_pc,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t      r_state,     w_state_next;
    logic [15:0] r_pc,        w_pc_next;
    logic        r_valid,     w_valid_next;
    logic [15:0] r_instr,     w_instr_next;
    logic [15:0] r_if_pc,     w_if_pc_next;
    logic [15:0] r_if_pc2,    w_if_pc2_next;
    logic [15:0] r_count,     w_count_next;

    logic [15:0] w_pc_plus2;
    logic        w_is_halt;

    assign w_pc_plus2 = r_pc + 16'd2;
    assign w_is_halt  = (imem_instr[15:12] == HALT_OP);

    // NOTE: every output of this block gets a hold default before any branch,
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_valid_next  = r_valid;
        w_instr_next  = r_instr;
        w_if_pc_next  = r_if_pc;
        w_if_pc2_next = r_if_pc2;
        w_count_next  = r_count;

        if (redirect_valid) begin
            // Flush: the IF/ID payload is kept but marked dead.
            w_pc_next    = {redirect_target[15:1], 1'b0};
            w_valid_next = 1'b0;
            w_state_next = S_RUN;
        end else if (!stall) begin
            case (r_state)
                S_RUN: begin
                    w_instr_next  = imem_instr;
                    w_if_pc_next  = r_pc;
                    w_if_pc2_next = w_pc_plus2;
                    w_valid_next  = 1'b1;
                    if (r_count != 16'hFFFF) begin
                        w_count_next = r_count + 16'd1;
                    end
                    if (w_is_halt) begin
                        w_state_next = S_HALT;
                    end else begin
                        w_pc_next = w_pc_plus2;
                    end
                end
                S_HALT: begin
                    w_valid_next = 1'b0;
                end
                default: begin
                    w_state_next = S_RUN;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_RUN;
            r_pc     <= RESET_PC;
            r_valid  <= 1'b0;
            r_instr  <= 16'h0000;
            r_if_pc  <= 16'h0000;
            r_if_pc2 <= 16'h0000;
            r_count  <= 16'h0000;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_valid  <= w_valid_next;
            r_instr  <= w_instr_next;
            r_if_pc  <= w_if_pc_next;
            r_if_pc2 <= w_if_pc2_next;
            r_count  <= w_count_next;
        end
    end

    assign imem_pc     = r_pc;
    assign if_valid    = r_valid;
    assign if_instr    = r_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus2 = r_if_pc2;
    assign halted      = (r_state == S_HALT);
    assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model predicts the outputs after each edge,
// the driver queues the prediction and a negedge monitor compares it with the DUT.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [15:0] imem_instr;
    logic [15:0] imem_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        halted;
    logic [15:0] fetch_count;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_instr      (imem_instr),
        .imem_pc         (imem_pc),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus2     (if_pc_plus2),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    // Word-addressed instruction ROM, read combinationally like Instruction_Memory.
    logic [15:0] rom [0:32767];
    assign imem_instr = rom[imem_pc[15:1]];

    typedef struct {
        logic [15:0] pc;
        logic        valid;
        logic [15:0] instr;
        logic [15:0] ipc;
        logic [15:0] ipc2;
        logic        halt;
        logic [15:0] count;
    } exp_t;

    exp_t exp_q [$];
    exp_t m;           // model of architectural state after the latest edge
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Behavioural reference: what the fetch stage should hold after one edge.
    task automatic model_edge(input bit rst, input bit stl, input bit rv, input logic [15:0] tgt);
        logic [15:0] word;
        word = rom[m.pc >> 1];
        if (rst) begin
            m = '{pc: 16'h0000, valid: 1'b0, instr: 16'h0000, ipc: 16'h0000,
                  ipc2: 16'h0000, halt: 1'b0, count: 16'h0000};
        end else if (rv) begin
            m.pc    = tgt & 16'hFFFE;
            m.valid = 1'b0;
            m.halt  = 1'b0;
        end else if (stl) begin
            // everything frozen
        end else if (m.halt) begin
            m.valid = 1'b0;
        end else begin
            m.instr = word;
            m.ipc   = m.pc;
            m.ipc2  = 16'((32'(m.pc) + 2) % 65536);
            m.valid = 1'b1;
            if (m.count < 16'hFFFF) m.count = m.count + 16'd1;
            if (word[15:12] == 4'hF) m.halt = 1'b1;
            else                     m.pc   = 16'((32'(m.pc) + 2) % 65536);
        end
    endtask

    // Drive one cycle; inputs change 1 time unit after the previous edge.
    task automatic step(input bit rst, input bit stl, input bit rv, input logic [15:0] tgt);
        reset           = rst;
        stall           = stl;
        redirect_valid  = rv;
        redirect_target = tgt;
        model_edge(rst, stl, rv, tgt);
        @(posedge clk);
        exp_q.push_back(m);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("imem_pc",     imem_pc,            e.pc);
            check("if_valid",    {15'd0, if_valid},  {15'd0, e.valid});
            check("if_instr",    if_instr,           e.instr);
            check("if_pc",       if_pc,              e.ipc);
            check("if_pc_plus2", if_pc_plus2,        e.ipc2);
            check("halted",      {15'd0, halted},    {15'd0, e.halt});
            check("fetch_count", fetch_count,        e.count);
        end
    end

    initial begin
        int budget;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0000;
        for (int i = 0; i < 32768; i++) rom[i] = 16'h1000 + 16'(i);
        m = '{pc: 16'h0000, valid: 1'b0, instr: 16'h0000, ipc: 16'h0000,
              ipc2: 16'h0000, halt: 1'b0, count: 16'h0000};

        // Reset then four plain fetches.
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        run(4);

        // Stall at pc=4 for three cycles, then release.
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        run(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
        run(2);

        // Redirect with odd target overrides stall.
        step(1'b0, 1'b1, 1'b1, 16'h0009);
        run(2);

        // HALT word at pc=6, then release by redirect.
        rom[3] = 16'hF000;
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        run(6);
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        run(2);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 16'hFFFE);
        run(2);

        // Reset mid-run and reset while halted.
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        run(6);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        run(1);

        // Randomised control and ROM contents.
        for (int i = 0; i < 32768; i++) rom[i] = 16'($urandom);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            step(r < 2, r >= 2 && r < 22, r >= 22 && r < 32, 16'($urandom));
        end

        // Saturation of the fetch counter; ROM free of HALT words.
        for (int i = 0; i < 32768; i++) rom[i] = 16'($urandom) & 16'h7FFF;
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        run(65540);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        run(2);
        step(1'b1, 1'b0, 1'b0, 16'h0000);

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk); #1;
            budget++;
        end
        check("scoreboard_drain", 16'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
